// File: rtl/seg_disp_sched.sv
// Round-robin share of one 3-digit seven-segment display between two value sources.
// Winner's 10-bit value is saturated, converted to BCD by double-dabble, then held for HOLD_CYC cycles.
module seg_disp_sched #(
    parameter int HOLD_CYC = 50_000_000,
    parameter int HOLD_W   = 26
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        req_a,
    input  logic [9:0]  val_a,
    output logic        ack_a,
    input  logic        req_b,
    input  logic [9:0]  val_b,
    output logic        ack_b,
    output logic [11:0] bcd_out,
    output logic        src_id,
    output logic        ovf,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, GRANT, CONV, HOLD} state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    state_t            state;
    logic              win;
    logic              last;
    logic [3:0]        conv_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              pend_ovf;
    logic [9:0]        bin;
    logic [11:0]       bcd;
    logic [11:0]       bcd_nxt;
    logic [9:0]        sel_val;
    logic              grant_ok;

    function automatic logic [9:0] sat999(input logic [9:0] v);
        return (v > 10'd999) ? 10'd999 : v;
    endfunction

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
    function automatic logic [11:0] dd_step(input logic [11:0] b, input logic msb);
        logic [11:0] t;
        t = b;
        for (int i = 0; i < 3; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                t[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return {t[10:0], msb};
    endfunction

    assign sel_val  = win ? val_b : val_a;
    assign grant_ok = (state == GRANT) && (win ? req_b : req_a);
    assign ack_a    = grant_ok && !win;
    assign ack_b    = grant_ok && win;
    assign bcd_nxt  = dd_step(bcd, bin[9]);

    // Conversion datapath: no reset, only meaningful while in CONV.
    always_ff @(posedge sys_clk) begin
        if (state == GRANT) begin
            bin <= sat999(sel_val);
            bcd <= 12'h000;
        end else if (state == CONV) begin
            bin <= {bin[8:0], 1'b0};
            bcd <= bcd_nxt;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            win      <= 1'b0;
            last     <= 1'b1;
            conv_cnt <= 4'd0;
            hold_cnt <= '0;
            pend_ovf <= 1'b0;
            bcd_out  <= 12'h000;
            src_id   <= 1'b0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        win   <= (req_a && req_b) ? !last : req_b;
                        state <= GRANT;
                        busy  <= 1'b1;
                    end
                end
                GRANT: begin
                    if (grant_ok) begin
                        last     <= win;
                        pend_ovf <= (sel_val > 10'd999);
                        conv_cnt <= 4'd0;
                        state    <= CONV;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                CONV: begin
                    if (conv_cnt == 4'd9) begin
                        bcd_out  <= bcd_nxt;
                        src_id   <= win;
                        ovf      <= pend_ovf;
                        hold_cnt <= '0;
                        state    <= HOLD;
                    end else begin
                        conv_cnt <= conv_cnt + 4'd1;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_disp_sched.sv
// Directed and randomized bench for seg_disp_sched with a short dwell (HOLD_CYC=4).
// Expected display values come from decimal arithmetic on the saturated input value.
module tb_seg_disp_sched;

    logic        clk;
    logic        rst;
    logic        req_a;
    logic [9:0]  val_a;
    logic        ack_a;
    logic        req_b;
    logic [9:0]  val_b;
    logic        ack_b;
    logic [11:0] bcd_out;
    logic        src_id;
    logic        ovf;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [11:0] mprev;
    bit          msrc;
    bit          movf;
    bit          mlast;

    seg_disp_sched #(.HOLD_CYC(4), .HOLD_W(3)) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .req_a(req_a),
        .val_a(val_a),
        .ack_a(ack_a),
        .req_b(req_b),
        .val_b(val_b),
        .ack_b(ack_b),
        .bcd_out(bcd_out),
        .src_id(src_id),
        .ovf(ovf),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [11:0] bcd_of(input int v);
        int s;
        s = (v > 999) ? 999 : v;
        return 12'((s / 100) * 256 + ((s / 10) % 10) * 16 + (s % 10));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        mprev = 12'h000;
        msrc  = 1'b0;
        movf  = 1'b0;
        mlast = 1'b1;
    endtask

    task automatic wait_ack(output int w, output bit got);
        w   = 0;
        got = 1'b0;
        while (w < 20) begin
            if (ack_a || ack_b) begin
                got = 1'b1;
                break;
            end
            tick();
            w++;
        end
    endtask

    // One full grant: ack, 10 conversion cycles, dwell, back to idle.
    task automatic run_txn(input bit exp_src, input int v, input int exp_wait, input bit drop_all);
        int          w;
        bit          got;
        logic [11:0] exp_bcd;
        wait_ack(w, got);
        chk("ack_seen", {31'd0, got}, 32'd1);
        if (!got) return;
        if (exp_wait >= 0) chk("ack_wait", w, exp_wait);
        chk("ack_a_src", {31'd0, ack_a}, {31'd0, !exp_src});
        chk("ack_b_src", {31'd0, ack_b}, {31'd0, exp_src});
        chk("busy_grant", {31'd0, busy}, 32'd1);
        tick();
        if (drop_all) begin
            req_a = 1'b0;
            req_b = 1'b0;
        end else if (exp_src) begin
            req_b = 1'b0;
        end else begin
            req_a = 1'b0;
        end
        #1;
        chk("ack_pulse_a", {31'd0, ack_a}, 32'd0);
        chk("ack_pulse_b", {31'd0, ack_b}, 32'd0);
        repeat (9) tick();
        chk("bcd_no_glitch", {20'd0, bcd_out}, {20'd0, mprev});
        tick();
        exp_bcd = bcd_of(v);
        chk("bcd_out", {20'd0, bcd_out}, {20'd0, exp_bcd});
        chk("src_id", {31'd0, src_id}, {31'd0, exp_src});
        chk("ovf", {31'd0, ovf}, {31'd0, (v > 999)});
        repeat (3) tick();
        chk("busy_hold", {31'd0, busy}, 32'd1);
        tick();
        chk("busy_idle", {31'd0, busy}, 32'd0);
        mprev = exp_bcd;
        msrc  = exp_src;
        movf  = (v > 999);
        mlast = exp_src;
    endtask

    initial begin
        int  w;
        bit  got;
        int  pat;
        int  va;
        int  vb;
        bit  es;

        rst   = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        val_a = 10'd0;
        val_b = 10'd0;

        do_reset();
        rst = 1'b1;
        tick();
        chk("rst_bcd", {20'd0, bcd_out}, 32'd0);
        chk("rst_src", {31'd0, src_id}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ack_a", {31'd0, ack_a}, 32'd0);
        chk("rst_ack_b", {31'd0, ack_b}, 32'd0);
        rst = 1'b0;

        // Single request from A.
        req_a = 1'b1;
        val_a = 10'd123;
        run_txn(1'b0, 123, 1, 1'b0);

        // Reset in the middle of a conversion, request stays pending.
        req_a = 1'b1;
        val_a = 10'd200;
        wait_ack(w, got);
        chk("mid_ack_seen", {31'd0, got}, 32'd1);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_bcd", {20'd0, bcd_out}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ack", {31'd0, ack_a}, 32'd0);
        tick();
        chk("mid_rst_bcd2", {20'd0, bcd_out}, 32'd0);
        rst   = 1'b0;
        mprev = 12'h000;
        mlast = 1'b1;
        run_txn(1'b0, 200, 1, 1'b0);

        // Both sources held: alternation starting with A after reset.
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        val_a = 10'd7;
        val_b = 10'd450;
        run_txn(1'b0, 7, 1, 1'b0);
        req_a = 1'b1;
        run_txn(1'b1, 450, 1, 1'b0);
        req_b = 1'b1;
        run_txn(1'b0, 7, 1, 1'b1);

        // Saturation then a small value.
        req_a = 1'b1;
        val_a = 10'd1023;
        run_txn(1'b0, 1023, 1, 1'b0);
        req_a = 1'b1;
        val_a = 10'd5;
        run_txn(1'b0, 5, 1, 1'b0);

        // B request withdrawn before grant.
        req_b = 1'b1;
        val_b = 10'd321;
        tick();
        req_b = 1'b0;
        #1;
        chk("drop_ack_b", {31'd0, ack_b}, 32'd0);
        chk("drop_ack_a", {31'd0, ack_a}, 32'd0);
        tick();
        chk("drop_busy", {31'd0, busy}, 32'd0);
        chk("drop_bcd", {20'd0, bcd_out}, {20'd0, mprev});
        chk("drop_src", {31'd0, src_id}, {31'd0, msrc});
        chk("drop_ovf", {31'd0, ovf}, {31'd0, movf});

        // B boundary values.
        req_b = 1'b1;
        val_b = 10'd0;
        run_txn(1'b1, 0, 1, 1'b0);
        req_b = 1'b1;
        val_b = 10'd999;
        run_txn(1'b1, 999, 1, 1'b0);

        // Randomized request patterns and values.
        for (int i = 0; i < 10; i++) begin
            pat   = int'($urandom_range(1, 3));
            va    = int'($urandom_range(0, 1023));
            vb    = int'($urandom_range(0, 1023));
            val_a = 10'(va);
            val_b = 10'(vb);
            req_a = pat[0];
            req_b = pat[1];
            es    = (pat == 3) ? !mlast : pat[1];
            run_txn(es, es ? vb : va, 1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
